// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event capture with round-robin scheduling onto one valid/ready port.
// Each channel edge-detects under its own mode; detected events wait as pending until granted.
module edge_event_arbiter #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned CH_W = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N_CH-1:0] pulse_i,
    input  logic            cfg_we_i,
    input  logic [CH_W-1:0] cfg_ch_i,
    input  logic [1:0]      cfg_mode_i,
    input  logic [N_CH-1:0] ovf_clr_i,
    output logic            evt_valid_o,
    input  logic            evt_ready_i,
    output logic [CH_W-1:0] evt_ch_o,
    output logic            evt_rise_o,
    output logic [N_CH-1:0] pend_o,
    output logic [N_CH-1:0] ovf_o
);

    typedef enum logic [0:0] {StIdle, StPresent} state_e;

    state_e                state_q, state_d;
    logic [N_CH-1:0][1:0]  mode_q, mode_d;
    logic [N_CH-1:0]       dly_q;
    logic [N_CH-1:0]       pend_q, pend_d;
    logic [N_CH-1:0]       ptype_q, ptype_d;
    logic [N_CH-1:0]       ovf_q, ovf_d;
    logic [CH_W-1:0]       ptr_q, ptr_d;
    logic [CH_W-1:0]       evt_ch_q, evt_ch_d;
    logic                  evt_rise_q, evt_rise_d;
    logic                  evt_valid_q, evt_valid_d;

    logic [N_CH-1:0]       rise, fall, qual;
    logic [CH_W-1:0]       sel;
    logic                  sel_found;
    logic                  grant;

    // Edge detection uses the previous-cycle sample regardless of mode.
    always_comb begin
        rise = pulse_i & ~dly_q;
        fall = ~pulse_i & dly_q;
        qual = '0;
        for (int c = 0; c < N_CH; c++) begin
            qual[c] = (rise[c] & mode_q[c][0]) | (fall[c] & mode_q[c][1]);
        end
    end

    // Round-robin search: first pending channel strictly after the last granted one.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        sel       = '0;
        sel_found = 1'b0;
        for (int unsigned i = 1; i <= N_CH; i++) begin
            idx = (32'(ptr_q) + i) % N_CH;
            if (!sel_found && pend_q[CH_W'(idx)]) begin
                sel_found = 1'b1;
                sel       = CH_W'(idx);
            end
        end
    end

    assign grant = (state_q == StIdle) && sel_found;

    always_comb begin
        pend_d  = pend_q;
        ptype_d = ptype_q;
        ovf_d   = ovf_q & ~ovf_clr_i;
        mode_d  = mode_q;

        if (grant) begin
            pend_d[sel] = 1'b0;
        end

        // A channel granted this cycle already reads as free, so a new edge re-arms it.
        for (int c = 0; c < N_CH; c++) begin
            if (qual[c]) begin
                if (pend_d[c]) begin
                    ovf_d[c] = 1'b1;
                end else begin
                    pend_d[c]  = 1'b1;
                    ptype_d[c] = rise[c];
                end
            end
        end

        if (cfg_we_i) begin
            mode_d[cfg_ch_i] = cfg_mode_i;
            if (cfg_mode_i == 2'b00) begin
                pend_d[cfg_ch_i]  = 1'b0;
                ptype_d[cfg_ch_i] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        evt_valid_d = evt_valid_q;
        evt_ch_d    = evt_ch_q;
        evt_rise_d  = evt_rise_q;
        ptr_d       = ptr_q;

        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    evt_valid_d = 1'b1;
                    evt_ch_d    = sel;
                    evt_rise_d  = ptype_q[sel];
                    ptr_d       = sel;
                    state_d     = StPresent;
                end
            end
            StPresent: begin
                if (evt_ready_i) begin
                    evt_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                evt_valid_d = 1'b0;
                state_d     = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            mode_q      <= '0;
            dly_q       <= '0;
            pend_q      <= '0;
            ptype_q     <= '0;
            ovf_q       <= '0;
            ptr_q       <= CH_W'(N_CH - 1);
            evt_ch_q    <= '0;
            evt_rise_q  <= 1'b0;
            evt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            dly_q       <= pulse_i;
            pend_q      <= pend_d;
            ptype_q     <= ptype_d;
            ovf_q       <= ovf_d;
            ptr_q       <= ptr_d;
            evt_ch_q    <= evt_ch_d;
            evt_rise_q  <= evt_rise_d;
            evt_valid_q <= evt_valid_d;
        end
    end

    assign evt_valid_o = evt_valid_q;
    assign evt_ch_o    = evt_ch_q;
    assign evt_rise_o  = evt_rise_q;
    assign pend_o      = pend_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed scenarios plus a random phase, each cycle checked
// against a behavioural model of pending events, overflow and round-robin grant order.
module tb_edge_event_arbiter;

    localparam int unsigned N_CH = 4;
    localparam int unsigned CH_W = 2;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [N_CH-1:0] pulse_i;
    logic            cfg_we_i;
    logic [CH_W-1:0] cfg_ch_i;
    logic [1:0]      cfg_mode_i;
    logic [N_CH-1:0] ovf_clr_i;
    logic            evt_valid_o;
    logic            evt_ready_i;
    logic [CH_W-1:0] evt_ch_o;
    logic            evt_rise_o;
    logic [N_CH-1:0] pend_o;
    logic [N_CH-1:0] ovf_o;

    edge_event_arbiter #(
        .N_CH(N_CH),
        .CH_W(CH_W)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .pulse_i    (pulse_i),
        .cfg_we_i   (cfg_we_i),
        .cfg_ch_i   (cfg_ch_i),
        .cfg_mode_i (cfg_mode_i),
        .ovf_clr_i  (ovf_clr_i),
        .evt_valid_o(evt_valid_o),
        .evt_ready_i(evt_ready_i),
        .evt_ch_o   (evt_ch_o),
        .evt_rise_o (evt_rise_o),
        .pend_o     (pend_o),
        .ovf_o      (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    int              m_mode [N_CH];
    bit [N_CH-1:0]   m_prev;
    bit [N_CH-1:0]   m_pend;
    bit [N_CH-1:0]   m_type;
    bit [N_CH-1:0]   m_ovf;
    bit              m_valid;
    int              m_ch;
    bit              m_rise;
    int              m_last;

    int seen_ch [$];
    bit seen_rise [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) m_mode[c] = 0;
        m_prev  = '0;
        m_pend  = '0;
        m_type  = '0;
        m_ovf   = '0;
        m_valid = 1'b0;
        m_ch    = 0;
        m_rise  = 1'b0;
        m_last  = N_CH - 1;
    endtask

    // One clock edge of the specified behaviour, from the inputs present at that edge.
    task automatic model_step();
        bit [N_CH-1:0] hit;
        int            pick;
        hit  = '0;
        pick = -1;
        for (int c = 0; c < N_CH; c++) begin
            hit[c] = (pulse_i[c] && !m_prev[c] && (m_mode[c] % 2) == 1)
                  || (!pulse_i[c] && m_prev[c] && m_mode[c] >= 2);
        end
        if (m_valid) begin
            if (evt_ready_i) m_valid = 1'b0;
        end else begin
            for (int i = 1; i <= N_CH; i++) begin
                if (pick < 0 && m_pend[(m_last + i) % N_CH]) pick = (m_last + i) % N_CH;
            end
        end
        if (pick >= 0) begin
            m_valid      = 1'b1;
            m_ch         = pick;
            m_rise       = m_type[pick];
            m_pend[pick] = 1'b0;
            m_last       = pick;
        end
        for (int c = 0; c < N_CH; c++) begin
            if (ovf_clr_i[c]) m_ovf[c] = 1'b0;
            if (hit[c]) begin
                if (m_pend[c]) m_ovf[c] = 1'b1;
                else begin
                    m_pend[c] = 1'b1;
                    m_type[c] = pulse_i[c];
                end
            end
        end
        if (cfg_we_i) begin
            m_mode[cfg_ch_i] = int'(cfg_mode_i);
            if (cfg_mode_i == 2'b00) begin
                m_pend[cfg_ch_i] = 1'b0;
                m_type[cfg_ch_i] = 1'b0;
            end
        end
        m_prev = pulse_i;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, evt_valid_o, m_valid);
        check({tag, ".ch"}, evt_ch_o, m_ch);
        check({tag, ".rise"}, evt_rise_o, m_rise);
        check({tag, ".pend"}, pend_o, m_pend);
        check({tag, ".ovf"}, ovf_o, m_ovf);
    endtask

    task automatic tick(input string tag);
        @(posedge clk_i);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic cfg(input int ch, input int mode);
        cfg_we_i   = 1'b1;
        cfg_ch_i   = CH_W'(ch);
        cfg_mode_i = 2'(mode);
        tick("cfg");
        cfg_we_i   = 1'b0;
    endtask

    task automatic apply_reset();
        cfg_we_i    = 1'b0;
        ovf_clr_i   = '0;
        evt_ready_i = 1'b0;
        rst_i       = 1'b1;
        #1;
        model_reset();
        check_all("reset");
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i       = 1'b1;
        pulse_i     = '0;
        cfg_we_i    = 1'b0;
        cfg_ch_i    = '0;
        cfg_mode_i  = '0;
        ovf_clr_i   = '0;
        evt_ready_i = 1'b0;
        #2;
        model_reset();
        check("rst.valid", evt_valid_o, 0);
        check("rst.pend", pend_o, 0);
        check("rst.ovf", ovf_o, 0);
        check("rst.ch", evt_ch_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Single rising event, latency and handshake.
        cfg(0, 1);
        evt_ready_i = 1'b1;
        pulse_i = 4'b0001;
        tick("t1.edge");
        check("t1.pend", pend_o, 4'b0001);
        check("t1.novalid", evt_valid_o, 0);
        tick("t1.present");
        check("t1.valid", evt_valid_o, 1);
        check("t1.ch", evt_ch_o, 0);
        check("t1.rise", evt_rise_o, 1);
        tick("t1.accept");
        check("t1.done", evt_valid_o, 0);
        check("t1.pend0", pend_o, 0);

        // All channels at once, both edges, grant order and bubbles.
        pulse_i = '0;
        apply_reset();
        for (int c = 0; c < N_CH; c++) cfg(c, 3);
        evt_ready_i = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            seen_ch.delete();
            seen_rise.delete();
            pulse_i = (pass == 0) ? 4'b1111 : 4'b0000;
            for (int i = 0; i < 10; i++) begin
                tick("t2");
                if (evt_valid_o) begin
                    seen_ch.push_back(int'(evt_ch_o));
                    seen_rise.push_back(evt_rise_o);
                end
            end
            check("t2.count", seen_ch.size(), 4);
            for (int i = 0; i < seen_ch.size(); i++) begin
                check("t2.order", seen_ch[i], i);
                check("t2.type", seen_rise[i], (pass == 0) ? 1 : 0);
            end
        end

        // Overflow on a channel pending behind a held event, then clear.
        pulse_i = '0;
        apply_reset();
        cfg(0, 1);
        cfg(1, 1);
        pulse_i = 4'b0001;
        tick("t3.a");
        tick("t3.b");
        pulse_i = 4'b0011;
        tick("t3.c");
        pulse_i = 4'b0001;
        tick("t3.d");
        pulse_i = 4'b0011;
        tick("t3.e");
        check("t3.ovf", ovf_o, 4'b0010);
        check("t3.pend", pend_o, 4'b0010);
        check("t3.held", evt_ch_o, 0);
        evt_ready_i = 1'b1;
        tick("t3.f");
        tick("t3.g");
        check("t3.ch1", evt_ch_o, 1);
        check("t3.ch1v", evt_valid_o, 1);
        tick("t3.h");
        tick("t3.i");
        check("t3.once", evt_valid_o, 0);
        check("t3.empty", pend_o, 0);
        ovf_clr_i = 4'b0010;
        tick("t3.clr");
        ovf_clr_i = '0;
        check("t3.ovfclr", ovf_o, 0);

        // Event held stable while consumer stalls.
        pulse_i = '0;
        apply_reset();
        cfg(2, 3);
        pulse_i = 4'b0100;
        tick("t4.a");
        tick("t4.b");
        for (int i = 0; i < 10; i++) begin
            tick("t4.hold");
            check("t4.valid", evt_valid_o, 1);
            check("t4.ch", evt_ch_o, 2);
            check("t4.rise", evt_rise_o, 1);
        end

        // Fall-only mode ignores rise; mode off clears pending.
        pulse_i = '0;
        apply_reset();
        cfg(0, 1);
        cfg(2, 2);
        pulse_i = 4'b0101;
        tick("t5.a");
        tick("t5.b");
        check("t5.norise", pend_o, 0);
        check("t5.ch0", evt_ch_o, 0);
        pulse_i = 4'b0001;
        tick("t5.fall");
        check("t5.pend2", pend_o, 4'b0100);
        cfg(2, 0);
        check("t5.off", pend_o, 0);
        check("t5.kept", evt_valid_o, 1);

        // Asynchronous reset mid-presentation.
        rst_i = 1'b1;
        #1;
        model_reset();
        check("t6.valid", evt_valid_o, 0);
        check("t6.ch", evt_ch_o, 0);
        check("t6.rise", evt_rise_o, 0);
        check("t6.pend", pend_o, 0);
        check_all("t6");
        pulse_i = '0;
        @(negedge clk_i);
        rst_i = 1'b0;
        cfg(0, 3);
        cfg(3, 3);
        evt_ready_i = 1'b1;
        pulse_i = 4'b1001;
        tick("t6.a");
        tick("t6.b");
        check("t6.first", evt_ch_o, 0);
        tick("t6.c");
        tick("t6.d");
        check("t6.second", evt_ch_o, 3);

        // Random traffic against the model.
        pulse_i = '0;
        apply_reset();
        for (int c = 0; c < N_CH; c++) cfg(c, int'($urandom_range(0, 3)));
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) pulse_i = pulse_i ^ N_CH'($urandom);
            evt_ready_i = ($urandom_range(0, 2) != 0);
            cfg_we_i    = ($urandom_range(0, 15) == 0);
            cfg_ch_i    = CH_W'($urandom);
            cfg_mode_i  = 2'($urandom);
            ovf_clr_i   = ($urandom_range(0, 7) == 0) ? N_CH'($urandom) : '0;
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
